// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-seven-segment display: FSM states,
// active-low segment patterns (bit order g..a) and the decimal range helper.
package seg7_pkg;

   localparam int MAX_DIGITS = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } seg7_state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Largest value representable in n decimal digits (10^n - 1).
   function automatic logic [31:0] pow10_minus1(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern (bit order g..a).
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_bin_display.sv
// Binary to multi-digit seven-segment display: sequential double-dabble for
// decimal, direct nibble mapping for hex, with overflow dashes and blanking.
module seg7_bin_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int BIN_WIDTH     = 14,
   parameter int BLANK_LEADING = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [BIN_WIDTH-1:0]    in_value,
   input  logic                    in_hex,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [NUM_DIGITS*7-1:0] hex_out,
   output logic                    out_valid,
   output logic                    overflow
);

   localparam int          BCD_W     = 4 * NUM_DIGITS;
   localparam int          CNT_W     = $clog2(BIN_WIDTH + 1);
   localparam logic [31:0] DEC_MAX   = pow10_minus1(NUM_DIGITS);
   localparam logic [31:0] HEX_LIMIT = 32'd1 << BCD_W;

   if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("seg7_bin_display: NUM_DIGITS must be in 1..%0d", MAX_DIGITS);
   end
   if (BIN_WIDTH < 4 || BIN_WIDTH > 20) begin : g_bad_width
      $error("seg7_bin_display: BIN_WIDTH must be in 4..20");
   end
   if (BLANK_LEADING != 0 && BLANK_LEADING != 1) begin : g_bad_blank
      $error("seg7_bin_display: BLANK_LEADING must be 0 or 1");
   end

   seg7_state_t             state_q, state_d;
   logic [BIN_WIDTH-1:0]    shift_q, shift_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_pend_q, ovf_pend_d;
   logic [NUM_DIGITS*7-1:0] hex_out_q, hex_out_d;
   logic                    ovf_q, ovf_d;

   logic [31:0]             value_ext;
   logic                    dec_ovf, hex_ovf, accept;
   logic [BCD_W-1:0]        bcd_adj, bcd_step, digit_src;
   logic                    load_out, final_ovf;
   logic [NUM_DIGITS-1:0]   blank_digit;
   logic                    nz_above;
   logic [NUM_DIGITS*7-1:0] seg_raw, seg_final;

   assign value_ext = 32'(in_value);
   assign dec_ovf   = (value_ext > DEC_MAX);
   assign hex_ovf   = (value_ext >= HEX_LIMIT);
   assign accept    = in_valid && in_ready;

   // Double-dabble step: correct every BCD digit >= 5, then shift in the next bit.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                              : bcd_q[4*gi +: 4];
   end
   assign bcd_step = (bcd_adj << 1) | BCD_W'(shift_q[BIN_WIDTH-1]);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      load_out   = 1'b0;
      final_ovf  = ovf_pend_q;
      digit_src  = bcd_step;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_hex) begin
                  state_d   = DONE;
                  load_out  = 1'b1;
                  final_ovf = hex_ovf;
                  digit_src = value_ext[BCD_W-1:0];
               end else begin
                  state_d    = CONVERT;
                  shift_d    = in_value;
                  bcd_d      = '0;
                  cnt_d      = '0;
                  ovf_pend_d = dec_ovf;
               end
            end
         end
         CONVERT: begin
            shift_d = shift_q << 1;
            bcd_d   = bcd_step;
            cnt_d   = cnt_q + CNT_W'(1);
            // Final step: the fully converted digits go straight to the output register.
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
               state_d  = DONE;
               load_out = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      nz_above    = 1'b0;
      blank_digit = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         blank_digit[k] = (BLANK_LEADING == 1) && (k != 0) && !nz_above
                          && (digit_src[4*k +: 4] == 4'd0);
         if (digit_src[4*k +: 4] != 4'd0) begin
            nz_above = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      seg7_hex_decoder u_dec (
         .nibble_i (digit_src[4*gi +: 4]),
         .seg_o    (seg_raw[7*gi +: 7])
      );
      assign seg_final[7*gi +: 7] = final_ovf        ? SEG_DASH  :
                                    blank_digit[gi]  ? SEG_BLANK :
                                                       seg_raw[7*gi +: 7];
   end

   assign hex_out_d = load_out ? seg_final : hex_out_q;
   assign ovf_d     = load_out ? final_ovf : ovf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         hex_out_q  <= '1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         hex_out_q  <= hex_out_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign hex_out   = hex_out_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
// Directed bench for seg7_bin_display (4 digits, 14-bit input), with a second
// instance built without leading-zero blanking.
module tb_seg7_bin_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S7 = 7'b1111000, S9 = 7'b0010000, SA = 7'b0001000,
                          SB = 7'b0000011, SC = 7'b1000110, SF = 7'b0001110,
                          BL = 7'b1111111, DS = 7'b0111111;

   logic        clk;
   logic        reset_n;
   logic [13:0] in_value;
   logic        in_hex;
   logic        in_valid;
   logic        in_ready, in_ready_nb;
   logic [27:0] hex_out, hex_out_nb;
   logic        out_valid, out_valid_nb;
   logic        overflow, overflow_nb;

   int checks = 0;
   int errors = 0;
   int lat, busy, pulses;

   seg7_bin_display #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_value  (in_value),
      .in_hex    (in_hex),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .hex_out   (hex_out),
      .out_valid (out_valid),
      .overflow  (overflow)
   );

   seg7_bin_display #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(0)) dut_nb (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_value  (in_value),
      .in_hex    (in_hex),
      .in_valid  (in_valid),
      .in_ready  (in_ready_nb),
      .hex_out   (hex_out_nb),
      .out_valid (out_valid_nb),
      .overflow  (overflow_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request, then watch until out_valid (bounded). Optionally
   // hammer in_valid with 5555 during cycles 3..10 of the conversion.
   task automatic run_value(input logic [13:0] v, input logic hx, input bit noise,
                            output int lat_o, output int busy_o);
      bit done;
      lat_o  = 0;
      busy_o = 0;
      done   = 1'b0;
      @(negedge clk);
      check("ready_before_accept", 32'(in_ready), 32'd1);
      in_value = v;
      in_hex   = hx;
      in_valid = 1'b1;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clk);
         if (!in_ready) busy_o++;
         if (out_valid) begin
            lat_o = n;
            done  = 1'b1;
         end
         in_valid = 1'b0;
         if (noise && n >= 3 && n <= 10) begin
            in_valid = 1'b1;
            in_value = 14'd5555;
            in_hex   = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b1;
      in_value = '0;
      in_hex   = 1'b0;
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_hex_out", 32'(hex_out), 32'hFFFFFFF);
      reset_n = 1'b1;
      $display("reset released: hex_out=%07h in_ready=%0b", hex_out, in_ready);

      // Decimal 1234: 15 busy cycles, pulse on cycle 15
      run_value(14'd1234, 1'b0, 1'b0, lat, busy);
      check("dec1234_latency", 32'(lat), 32'd15);
      check("dec1234_busy", 32'(busy), 32'd15);
      check("dec1234_hex_out", 32'(hex_out), 32'({S1, S2, S3, S4}));
      check("dec1234_overflow", 32'(overflow), 32'd0);
      $display("dec 1234: lat=%0d busy=%0d hex_out=%07h ovf=%0b", lat, busy, hex_out, overflow);
      @(negedge clk);
      check("dec1234_pulse_end", 32'(out_valid), 32'd0);
      check("dec1234_ready_back", 32'(in_ready), 32'd1);
      check("dec1234_hold", 32'(hex_out), 32'({S1, S2, S3, S4}));

      run_value(14'd7, 1'b0, 1'b0, lat, busy);
      check("dec7_blank", 32'(hex_out), 32'({BL, BL, BL, S7}));
      check("dec7_noblank", 32'(hex_out_nb), 32'({S0, S0, S0, S7}));
      $display("dec 7: hex_out=%07h no_blank=%07h", hex_out, hex_out_nb);

      run_value(14'd0, 1'b0, 1'b0, lat, busy);
      check("dec0_hex_out", 32'(hex_out), 32'({BL, BL, BL, S0}));
      check("dec0_overflow", 32'(overflow), 32'd0);
      $display("dec 0: hex_out=%07h ovf=%0b", hex_out, overflow);

      run_value(14'd9999, 1'b0, 1'b0, lat, busy);
      check("dec9999_hex_out", 32'(hex_out), 32'({S9, S9, S9, S9}));
      check("dec9999_overflow", 32'(overflow), 32'd0);
      $display("dec 9999: hex_out=%07h ovf=%0b", hex_out, overflow);

      run_value(14'd1050, 1'b0, 1'b0, lat, busy);
      check("dec1050_hex_out", 32'(hex_out), 32'({S1, S0, S5, S0}));
      $display("dec 1050: hex_out=%07h", hex_out);

      run_value(14'h3AF, 1'b1, 1'b0, lat, busy);
      check("hex3AF_latency", 32'(lat), 32'd1);
      check("hex3AF_hex_out", 32'(hex_out), 32'({BL, S3, SA, SF}));
      check("hex3AF_overflow", 32'(overflow), 32'd0);
      $display("hex 3AF: lat=%0d hex_out=%07h", lat, hex_out);

      run_value(14'h0B0C, 1'b1, 1'b0, lat, busy);
      check("hexB0C_hex_out", 32'(hex_out), 32'({BL, SB, S0, SC}));
      $display("hex B0C: hex_out=%07h", hex_out);

      run_value(14'h3FFF, 1'b1, 1'b0, lat, busy);
      check("hex3FFF_hex_out", 32'(hex_out), 32'({S3, SF, SF, SF}));
      $display("hex 3FFF: hex_out=%07h", hex_out);

      // Requests during CONVERT must be ignored
      run_value(14'd1234, 1'b0, 1'b1, lat, busy);
      check("ignore_latency", 32'(lat), 32'd15);
      check("ignore_hex_out", 32'(hex_out), 32'({S1, S2, S3, S4}));
      @(negedge clk);
      check("ignore_no_second", 32'(out_valid), 32'd0);
      check("ignore_ready", 32'(in_ready), 32'd1);
      $display("ignore 5555: lat=%0d hex_out=%07h", lat, hex_out);

      run_value(14'd10000, 1'b0, 1'b0, lat, busy);
      check("dec10000_hex_out", 32'(hex_out), 32'({DS, DS, DS, DS}));
      check("dec10000_overflow", 32'(overflow), 32'd1);
      $display("dec 10000: hex_out=%07h ovf=%0b", hex_out, overflow);

      // Reset during CONVERT cycle 6 aborts the conversion
      @(negedge clk);
      in_value = 14'd4321;
      in_hex   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy", 32'(in_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("abort_hex_out", 32'(hex_out), 32'hFFFFFFF);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_overflow", 32'(overflow), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      pulses  = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);
      check("abort_still_blank", 32'(hex_out), 32'hFFFFFFF);
      $display("abort: pulses=%0d hex_out=%07h", pulses, hex_out);

      run_value(14'd4321, 1'b0, 1'b0, lat, busy);
      check("post_reset_latency", 32'(lat), 32'd15);
      check("post_reset_hex_out", 32'(hex_out), 32'({S4, S3, S2, S1}));
      $display("dec 4321 after reset: lat=%0d hex_out=%07h", lat, hex_out);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
